// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared types and widths for the RAM controller.
//   ADDR_W  - RAM word address width
//   DATA_W  - RAM data width
//   state_t - controller FSM state encoding
//   drives_bus() - states in which the controller owns the data bus
package ram_ctrl_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        RD_ACCESS,
        TURN
    } state_t;

    function automatic logic drives_bus(input state_t s);
        return (s == WR_SETUP) || (s == WR_STROBE) || (s == WR_HOLD);
    endfunction

endpackage

// File: rtl/ram_ctrl.sv
// ram_ctrl: host-request controller for a 16x8 asynchronous single-port RAM
// with a shared bidirectional data bus.
//
// Ports:
//   clock, resetn          - rising-edge clock, asynchronous active-low reset
//   req_valid_in/ready_out - host request handshake (accepted when both high)
//   req_we_in              - 1 = write, 0 = read
//   req_addr_in            - word address
//   req_wdata_in           - write data
//   wr_done_out            - one-cycle pulse when a write completes
//   rsp_valid_out/ready_in - read response handshake (single buffer)
//   rsp_rdata_out          - read data
//   we_out, enable_out     - RAM write / read strobes (never both high)
//   addr_out               - RAM address, held for the whole operation
//   data                   - shared RAM data bus
//
// RD_WAIT is the number of cycles enable_out is held before sampling (1..4).
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned RD_WAIT = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic              req_we_in,
    input  logic [ADDR_W-1:0] req_addr_in,
    input  logic [DATA_W-1:0] req_wdata_in,
    output logic              wr_done_out,
    output logic              rsp_valid_out,
    input  logic              rsp_ready_in,
    output logic [DATA_W-1:0] rsp_rdata_out,
    output logic              we_out,
    output logic              enable_out,
    output logic [ADDR_W-1:0] addr_out,
    inout  wire  [DATA_W-1:0] data
);

    // Counter reload: the last RD_ACCESS cycle is the one where the count is 0.
    localparam logic [1:0] WAIT_INIT = 2'(RD_WAIT - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_wait;
    logic [1:0]          w_wait_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we;
    logic                r_we_out;
    logic                r_enable_out;
    logic                r_wr_done;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_accept;
    logic                w_capture;
    logic                w_drive;

    assign req_ready_out = (r_state == IDLE) && !r_rsp_valid;

    // Decoded from registered state so reset releases the bus with no clock.
    assign w_drive = drives_bus(r_state) && r_we;
    assign data    = w_drive ? r_wdata : 'z;

    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid_in && req_ready_out) begin
                    w_accept = 1'b1;
                    if (req_we_in) begin
                        w_state_next = WR_SETUP;
                    end else begin
                        w_state_next = RD_ACCESS;
                        w_wait_next  = WAIT_INIT;
                    end
                end
            end
            WR_SETUP:  w_state_next = WR_STROBE;
            WR_STROBE: w_state_next = WR_HOLD;
            WR_HOLD:   w_state_next = IDLE;
            RD_ACCESS: begin
                if (r_wait == 2'd0) begin
                    w_state_next = TURN;
                    w_capture    = 1'b1;
                end else begin
                    w_wait_next = r_wait - 2'd1;
                end
            end
            // Bus turnaround: nobody drives, so a following write cannot
            // collide with the RAM still releasing the bus.
            TURN:      w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_wait       <= 2'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_we_out     <= 1'b0;
            r_enable_out <= 1'b0;
            r_wr_done    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
            if (w_accept) begin
                r_addr  <= req_addr_in;
                r_wdata <= req_wdata_in;
                r_we    <= req_we_in;
            end
            // Strobes are registered from the next state so they line up
            // exactly with the state they belong to.
            r_we_out     <= (w_state_next == WR_STROBE);
            r_enable_out <= (w_state_next == RD_ACCESS);
            r_wr_done    <= (w_state_next == WR_HOLD);
            if (w_capture) begin
                r_rdata     <= data;
                r_rsp_valid <= 1'b1;
            end else if (r_rsp_valid && rsp_ready_in) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign we_out        = r_we_out;
    assign enable_out    = r_enable_out;
    assign addr_out      = r_addr;
    assign wr_done_out   = r_wr_done;
    assign rsp_valid_out = r_rsp_valid;
    assign rsp_rdata_out = r_rdata;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed bench for ram_ctrl. Instance 0 uses RD_WAIT=1,
// instance 1 uses RD_WAIT=4; each has its own behavioural async RAM on a
// pulled-up bus, so a released bus reads 8'hFF.
module tb_ram_ctrl;

    logic       clock;
    logic       resetn;
    logic       req_valid [2];
    logic       req_we    [2];
    logic [3:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       rsp_ready [2];
    logic       req_ready [2];
    logic       wr_done   [2];
    logic       rsp_valid [2];
    logic [7:0] rdata     [2];
    logic       we        [2];
    logic       en        [2];
    logic [3:0] addr      [2];
    wire  [7:0] bus0;
    wire  [7:0] bus1;

    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];
    logic [7:0] exp_mem [2][16];

    int n_cmp = 0;
    int n_err = 0;

    ram_ctrl #(.RD_WAIT(1)) u_dut0 (
        .clock(clock), .resetn(resetn),
        .req_valid_in(req_valid[0]), .req_ready_out(req_ready[0]),
        .req_we_in(req_we[0]), .req_addr_in(req_addr[0]), .req_wdata_in(req_wdata[0]),
        .wr_done_out(wr_done[0]), .rsp_valid_out(rsp_valid[0]),
        .rsp_ready_in(rsp_ready[0]), .rsp_rdata_out(rdata[0]),
        .we_out(we[0]), .enable_out(en[0]), .addr_out(addr[0]), .data(bus0)
    );

    ram_ctrl #(.RD_WAIT(4)) u_dut1 (
        .clock(clock), .resetn(resetn),
        .req_valid_in(req_valid[1]), .req_ready_out(req_ready[1]),
        .req_we_in(req_we[1]), .req_addr_in(req_addr[1]), .req_wdata_in(req_wdata[1]),
        .wr_done_out(wr_done[1]), .rsp_valid_out(rsp_valid[1]),
        .rsp_ready_in(rsp_ready[1]), .rsp_rdata_out(rdata[1]),
        .we_out(we[1]), .enable_out(en[1]), .addr_out(addr[1]), .data(bus1)
    );

    // Async RAMs: drive on read enable, latch on falling write enable.
    pullup (bus0);
    pullup (bus1);
    assign bus0 = (en[0] && !we[0]) ? mem0[addr[0]] : 8'hzz;
    assign bus1 = (en[1] && !we[1]) ? mem1[addr[1]] : 8'hzz;
    always @(negedge we[0]) if (resetn) mem0[addr[0]] <= bus0;
    always @(negedge we[1]) if (resetn) mem1[addr[1]] <= bus1;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200us");
        $fatal(1);
    end

    function automatic logic [7:0] bus_of(input int k);
        return (k == 0) ? bus0 : bus1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitors, sampled on the falling edge.
    int n_overlap [2] = '{0, 0};
    int n_rdbus   [2] = '{0, 0};
    int n_turn    [2] = '{0, 0};
    int run       [2] = '{0, 0};
    int run_min   [2] = '{99, 99};
    int run_max   [2] = '{0, 0};
    int we_cyc    [2] = '{0, 0};
    logic prev_en [2] = '{1'b0, 1'b0};

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (we[k] && en[k]) n_overlap[k] <= n_overlap[k] + 1;
            if (en[k] && bus_of(k) !== exp_mem[k][addr[k]]) n_rdbus[k] <= n_rdbus[k] + 1;
            if (prev_en[k] && !en[k] && bus_of(k) !== 8'hFF) n_turn[k] <= n_turn[k] + 1;
            if (we[k]) we_cyc[k] <= we_cyc[k] + 1;
            if (en[k]) begin
                run[k] <= run[k] + 1;
            end else if (run[k] != 0) begin
                if (run[k] < run_min[k]) run_min[k] <= run[k];
                if (run[k] > run_max[k]) run_max[k] <= run[k];
                run[k] <= 0;
            end
            prev_en[k] <= en[k];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic w, input logic [3:0] a,
                           input logic [7:0] d);
        req_valid[k] = v;
        req_we[k]    = w;
        req_addr[k]  = a;
        req_wdata[k] = d;
    endtask

    task automatic wait_ready(input int k);
        int n;
        n = 0;
        while (!req_ready[k] && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready[k]) check_eq("ready_timeout", {31'b0, req_ready[k]}, 32'd1);
    endtask

    task automatic wr(input int k, input logic [3:0] a, input logic [7:0] d);
        wait_ready(k);
        set_req(k, 1'b1, 1'b1, a, d);
        tick();
        req_valid[k] = 1'b0;
        repeat (3) tick();
        exp_mem[k][a] = d;
    endtask

    task automatic rd(input int k, input logic [3:0] a, input int exp_lat);
        int lat;
        wait_ready(k);
        rsp_ready[k] = 1'b1;
        set_req(k, 1'b1, 1'b0, a, 8'h00);
        tick();
        req_valid[k] = 1'b0;
        lat = 0;
        while (!rsp_valid[k] && lat < 12) begin
            tick();
            lat++;
        end
        check_eq($sformatf("rd_lat%0d_a%0d", k, a), lat, exp_lat);
        check_eq($sformatf("rd_data%0d_a%0d", k, a), {24'b0, rdata[k]}, {24'b0, exp_mem[k][a]});
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_req(k, 1'b0, 1'b0, 4'h0, 8'h00);
            rsp_ready[k] = 1'b0;
        end
        repeat (3) tick();

        // Reset state
        for (int k = 0; k < 2; k++) begin
            check_eq("rst_we", {31'b0, we[k]}, 32'd0);
            check_eq("rst_en", {31'b0, en[k]}, 32'd0);
            check_eq("rst_addr", {28'b0, addr[k]}, 32'd0);
            check_eq("rst_done", {31'b0, wr_done[k]}, 32'd0);
            check_eq("rst_rspv", {31'b0, rsp_valid[k]}, 32'd0);
            check_eq("rst_rdata", {24'b0, rdata[k]}, 32'd0);
            check_eq("rst_bus", {24'b0, bus_of(k)}, 32'hFF);
        end
        resetn = 1'b1;
        tick();
        check_eq("ready_after_rst", {31'b0, req_ready[0]}, 32'd1);

        // Write A5 to addr 3, request inputs scrambled while busy
        set_req(0, 1'b1, 1'b1, 4'd3, 8'hA5);
        tick();
        set_req(0, 1'b0, 1'b0, 4'hE, 8'h00);
        check_eq("w_setup_we", {31'b0, we[0]}, 32'd0);
        check_eq("w_setup_bus", {24'b0, bus0}, 32'hA5);
        check_eq("w_setup_addr", {28'b0, addr[0]}, 32'd3);
        check_eq("w_setup_ready", {31'b0, req_ready[0]}, 32'd0);
        tick();
        check_eq("w_strobe_we", {31'b0, we[0]}, 32'd1);
        check_eq("w_strobe_bus", {24'b0, bus0}, 32'hA5);
        check_eq("w_strobe_done", {31'b0, wr_done[0]}, 32'd0);
        tick();
        check_eq("w_hold_we", {31'b0, we[0]}, 32'd0);
        check_eq("w_hold_done", {31'b0, wr_done[0]}, 32'd1);
        check_eq("w_hold_bus", {24'b0, bus0}, 32'hA5);
        check_eq("w_hold_addr", {28'b0, addr[0]}, 32'd3);
        tick();
        check_eq("w_idle_done", {31'b0, wr_done[0]}, 32'd0);
        check_eq("w_idle_bus", {24'b0, bus0}, 32'hFF);
        check_eq("w_idle_ready", {31'b0, req_ready[0]}, 32'd1);
        check_eq("w_mem3", {24'b0, mem0[3]}, 32'hA5);
        exp_mem[0][3] = 8'hA5;

        // Back-to-back writes: next accept 4 cycles after the first
        set_req(0, 1'b1, 1'b1, 4'd5, 8'h11);
        tick();
        set_req(0, 1'b1, 1'b1, 4'd6, 8'h22);
        tick();
        check_eq("b2b_hold_addr", {28'b0, addr[0]}, 32'd5);
        tick();
        check_eq("b2b_busy", {31'b0, req_ready[0]}, 32'd0);
        tick();
        check_eq("b2b_ready", {31'b0, req_ready[0]}, 32'd1);
        tick();
        req_valid[0] = 1'b0;
        check_eq("b2b_addr2", {28'b0, addr[0]}, 32'd6);
        check_eq("b2b_bus2", {24'b0, bus0}, 32'h22);
        repeat (3) tick();
        check_eq("b2b_mem5", {24'b0, mem0[5]}, 32'h11);
        check_eq("b2b_mem6", {24'b0, mem0[6]}, 32'h22);
        exp_mem[0][5] = 8'h11;
        exp_mem[0][6] = 8'h22;

        // Read addr 3, response held off 5 cycles with a write pending
        rsp_ready[0] = 1'b0;
        set_req(0, 1'b1, 1'b0, 4'd3, 8'h00);
        tick();
        check_eq("r_acc_en", {31'b0, en[0]}, 32'd1);
        check_eq("r_acc_we", {31'b0, we[0]}, 32'd0);
        check_eq("r_acc_rspv", {31'b0, rsp_valid[0]}, 32'd0);
        set_req(0, 1'b1, 1'b1, 4'd9, 8'h99);
        tick();
        check_eq("r_turn_en", {31'b0, en[0]}, 32'd0);
        check_eq("r_turn_bus", {24'b0, bus0}, 32'hFF);
        check_eq("r_rspv", {31'b0, rsp_valid[0]}, 32'd1);
        check_eq("r_rdata", {24'b0, rdata[0]}, 32'hA5);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("hold_rspv", {31'b0, rsp_valid[0]}, 32'd1);
            check_eq("hold_rdata", {24'b0, rdata[0]}, 32'hA5);
            check_eq("hold_ready", {31'b0, req_ready[0]}, 32'd0);
            check_eq("hold_addr", {28'b0, addr[0]}, 32'd3);
        end
        rsp_ready[0] = 1'b1;
        tick();
        check_eq("consume_rspv", {31'b0, rsp_valid[0]}, 32'd0);
        check_eq("consume_ready", {31'b0, req_ready[0]}, 32'd1);
        tick();
        req_valid[0] = 1'b0;
        check_eq("pend_w_addr", {28'b0, addr[0]}, 32'd9);
        check_eq("pend_w_bus", {24'b0, bus0}, 32'h99);
        repeat (3) tick();
        exp_mem[0][9] = 8'h99;

        // Read then immediate write: TURN separates them
        set_req(0, 1'b1, 1'b0, 4'd3, 8'h00);
        tick();
        set_req(0, 1'b1, 1'b1, 4'd7, 8'h3C);
        tick();
        check_eq("rw_turn_en", {31'b0, en[0]}, 32'd0);
        check_eq("rw_turn_we", {31'b0, we[0]}, 32'd0);
        check_eq("rw_turn_bus", {24'b0, bus0}, 32'hFF);
        check_eq("rw_rdata", {24'b0, rdata[0]}, 32'hA5);
        tick();
        check_eq("rw_idle_ready", {31'b0, req_ready[0]}, 32'd1);
        check_eq("rw_idle_bus", {24'b0, bus0}, 32'hFF);
        tick();
        req_valid[0] = 1'b0;
        check_eq("rw_w_addr", {28'b0, addr[0]}, 32'd7);
        check_eq("rw_w_bus", {24'b0, bus0}, 32'h3C);
        repeat (3) tick();
        check_eq("rw_mem7", {24'b0, mem0[7]}, 32'h3C);
        exp_mem[0][7] = 8'h3C;

        // Reset in WR_STROBE aborts without a clock
        set_req(0, 1'b1, 1'b1, 4'd12, 8'h77);
        tick();
        req_valid[0] = 1'b0;
        tick();
        check_eq("abort_pre_we", {31'b0, we[0]}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        check_eq("abort_we", {31'b0, we[0]}, 32'd0);
        check_eq("abort_bus", {24'b0, bus0}, 32'hFF);
        check_eq("abort_en", {31'b0, en[0]}, 32'd0);
        check_eq("abort_addr", {28'b0, addr[0]}, 32'd0);
        check_eq("abort_done", {31'b0, wr_done[0]}, 32'd0);
        check_eq("abort_rdata", {24'b0, rdata[0]}, 32'd0);
        check_eq("abort_rspv", {31'b0, rsp_valid[0]}, 32'd0);
        #2 resetn = 1'b1;
        tick();
        check_eq("abort_ready", {31'b0, req_ready[0]}, 32'd1);
        check_eq("abort_post_we", {31'b0, we[0]}, 32'd0);

        // RD_WAIT=1 read still works after the abort
        rd(0, 4'd3, 1);

        // RD_WAIT=4: fill all 16 words, then read them back
        for (int a = 0; a < 16; a++) wr(1, 4'(a), 8'(a) ^ 8'h5A);
        for (int a = 0; a < 16; a++) rd(1, 4'(a), 4);
        tick();

        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("overlap%0d", k), n_overlap[k], 32'd0);
            check_eq($sformatf("rd_bus%0d", k), n_rdbus[k], 32'd0);
            check_eq($sformatf("turn_bus%0d", k), n_turn[k], 32'd0);
        end
        check_eq("en_min0", run_min[0], 32'd1);
        check_eq("en_max0", run_max[0], 32'd1);
        check_eq("en_min1", run_min[1], 32'd4);
        check_eq("en_max1", run_max[1], 32'd4);
        check_eq("we_cycles1", we_cyc[1], 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
